// File: rtl/switch_mem_pkg.sv
// Shared types and constants for the switch port-address memory controller:
// FSM state encoding, CSR bit positions and bus-width helpers.
package switch_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_COMMIT
  } state_t;

  localparam int CSR_COMMIT_BIT = 0;
  localparam int CSR_BUSY_BIT   = 1;
  localparam int CSR_DUP_BIT    = 2;
  localparam int CSR_VALID_BIT  = 3;

  // One extra address above the port registers is reserved for the CSR.
  function automatic int calc_addr_w(input int num_ports);
    return $clog2(num_ports + 1);
  endfunction

endpackage

// File: rtl/switch_mem_ctrl_dup_check.sv
// Combinational duplicate detector: flags when the shadow entry selected by
// idx equals any other shadow entry.
module switch_dup_check #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS*DATA_W-1:0] shadow_flat,
  input  logic [IDX_W-1:0]            idx,
  output logic                        dup
);

  logic [DATA_W-1:0]    sel_val;
  logic [NUM_PORTS-1:0] match_vec;

  assign sel_val = shadow_flat[idx*DATA_W +: DATA_W];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cmp
      assign match_vec[gi] = (IDX_W'(gi) != idx) &&
                             (shadow_flat[gi*DATA_W +: DATA_W] == sel_val);
    end
  endgenerate

  assign dup = |match_vec;

endmodule

// File: rtl/switch_mem_ctrl.sv
// Register-mapped port address table with shadow/active double buffering.
// A CSR commit checks the shadows for duplicates before copying them live.
module switch_mem_ctrl
  import switch_mem_pkg::*;
#(
  parameter int  NUM_PORTS = 4,
  parameter int  DATA_W    = 8,
  localparam int ADDR_W    = calc_addr_w(NUM_PORTS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mem_en,
  input  logic                        mem_rd_wr,
  input  logic [ADDR_W-1:0]           mem_add,
  input  logic [DATA_W-1:0]           mem_wdata,
  output logic [DATA_W-1:0]           mem_rdata,
  output logic                        mem_rvalid,
  output logic                        mem_err,
  output logic [NUM_PORTS*DATA_W-1:0] port_addr,
  output logic                        cfg_valid
);

  localparam int                IDX_W    = $clog2(NUM_PORTS);
  localparam logic [ADDR_W-1:0] CSR_ADDR = ADDR_W'(NUM_PORTS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PORTS - 1);

  state_t                      state_reg;
  logic [IDX_W-1:0]            idx_reg;
  logic                        dup_err_reg;
  logic                        cfg_valid_reg;
  logic [DATA_W-1:0]           shadow_reg [NUM_PORTS];
  logic [DATA_W-1:0]           active_reg [NUM_PORTS];
  logic [NUM_PORTS*DATA_W-1:0] shadow_flat;
  logic                        busy;
  logic                        port_sel;
  logic                        csr_sel;
  logic                        dup_found;
  logic [IDX_W-1:0]            port_idx;
  logic [DATA_W-1:0]           csr_value;

  assign busy      = (state_reg != ST_IDLE);
  assign port_sel  = (mem_add < CSR_ADDR);
  assign csr_sel   = (mem_add == CSR_ADDR);
  assign port_idx  = mem_add[IDX_W-1:0];
  assign cfg_valid = cfg_valid_reg;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_flat
      assign shadow_flat[gi*DATA_W +: DATA_W] = shadow_reg[gi];
      assign port_addr[gi*DATA_W +: DATA_W]   = active_reg[gi];
    end
  endgenerate

  always_comb begin
    csr_value                 = '0;
    csr_value[CSR_BUSY_BIT]   = busy;
    csr_value[CSR_DUP_BIT]    = dup_err_reg;
    csr_value[CSR_VALID_BIT]  = cfg_valid_reg;
  end

  switch_dup_check #(
    .NUM_PORTS (NUM_PORTS),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W)
  ) u_dup_check (
    .shadow_flat (shadow_flat),
    .idx         (idx_reg),
    .dup         (dup_found)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      dup_err_reg   <= 1'b0;
      cfg_valid_reg <= 1'b0;
      mem_rdata     <= '0;
      mem_rvalid    <= 1'b0;
      mem_err       <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
    end else begin
      mem_rvalid <= 1'b0;
      mem_err    <= 1'b0;

      if (mem_en) begin
        if (!mem_rd_wr) begin
          mem_rvalid <= 1'b1;
          if (port_sel) begin
            mem_rdata <= shadow_reg[port_idx];
          end else if (csr_sel) begin
            mem_rdata <= csr_value;
          end else begin
            mem_rdata <= '0;
            mem_err   <= 1'b1;
          end
        end else if (busy || !(port_sel || csr_sel)) begin
          mem_err <= 1'b1;
        end else if (port_sel) begin
          shadow_reg[port_idx] <= mem_wdata;
        end else begin
          // Starting a commit always clears the sticky duplicate flag.
          if (mem_wdata[CSR_DUP_BIT] || mem_wdata[CSR_COMMIT_BIT]) begin
            dup_err_reg <= 1'b0;
          end
          if (mem_wdata[CSR_COMMIT_BIT]) begin
            state_reg <= ST_CHECK;
            idx_reg   <= '0;
          end
        end
      end

      case (state_reg)
        ST_CHECK: begin
          if (dup_found) begin
            dup_err_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end else if (idx_reg == LAST_IDX) begin
            state_reg <= ST_COMMIT;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            active_reg[i] <= shadow_reg[i];
          end
          cfg_valid_reg <= 1'b1;
          state_reg     <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_mem_ctrl.sv
// Bench for switch_mem_ctrl: directed and random bus traffic compared against
// a register-table model that tracks commit timing by cycle count.
module tb_switch_mem_ctrl;

  logic        clock;
  logic        reset;
  logic        mem_en;
  logic        mem_rd_wr;
  logic [2:0]  mem_add;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic        mem_err;
  logic [31:0] port_addr;
  logic        cfg_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] shadow_m [4];
  logic [7:0] active_m [4];
  bit         cfg_valid_m;
  bit         dup_err_m;
  logic [7:0] last_rdata_m;

  switch_mem_ctrl #(
    .NUM_PORTS (4),
    .DATA_W    (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_en     (mem_en),
    .mem_rd_wr  (mem_rd_wr),
    .mem_add    (mem_add),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_err    (mem_err),
    .port_addr  (port_addr),
    .cfg_valid  (cfg_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] active_flat();
    return {active_m[3], active_m[2], active_m[1], active_m[0]};
  endfunction

  function automatic logic [7:0] csr_model(input bit busy);
    return {4'b0, cfg_valid_m, dup_err_m, busy, 1'b0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      shadow_m[i] = 8'h00;
      active_m[i] = 8'h00;
    end
    cfg_valid_m  = 1'b0;
    dup_err_m    = 1'b0;
    last_rdata_m = 8'h00;
  endtask

  // One bus access; the response is checked one clock edge later.
  task automatic do_access(input logic wr, input logic [2:0] addr,
                           input logic [7:0] data, input bit busy_now);
    logic [7:0] csr_now;
    logic [7:0] exp_data;
    bit         exp_err;
    csr_now   = csr_model(busy_now);
    mem_en    = 1'b1;
    mem_rd_wr = wr;
    mem_add   = addr;
    mem_wdata = data;
    step();
    mem_en = 1'b0;
    if (wr) begin
      exp_err = busy_now || (addr > 3'd4);
      chk("wr_err", 32'(mem_err), 32'(exp_err));
      chk("wr_rvalid", 32'(mem_rvalid), 32'd0);
      chk("rdata_hold", 32'(mem_rdata), 32'(last_rdata_m));
      if (!exp_err) begin
        if (addr < 3'd4) shadow_m[addr[1:0]] = data;
        else if (data[0] || data[2]) dup_err_m = 1'b0;
      end
      $display("wr addr=%0d data=%02h busy=%0b err=%0b", addr, data, busy_now, mem_err);
    end else begin
      if (addr < 3'd4)       exp_data = shadow_m[addr[1:0]];
      else if (addr == 3'd4) exp_data = csr_now;
      else                   exp_data = 8'h00;
      exp_err = (addr > 3'd4);
      chk("rd_rvalid", 32'(mem_rvalid), 32'd1);
      chk("rd_data", 32'(mem_rdata), 32'(exp_data));
      chk("rd_err", 32'(mem_err), 32'(exp_err));
      last_rdata_m = exp_data;
      $display("rd addr=%0d data=%02h exp=%02h err=%0b", addr, mem_rdata, exp_data, mem_err);
    end
  endtask

  // Commit: the check walks the ports until the first one with a twin, or
  // takes NUM_PORTS cycles plus one commit cycle when all are distinct.
  task automatic run_commit(input logic [7:0] wdata, input bit inject);
    logic [7:0] snap [4];
    bit         dup;
    int         k;
    int         t;
    do_access(1'b1, 3'd4, wdata, 1'b0);
    snap = shadow_m;
    dup  = 1'b0;
    k    = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (!dup && i != j && snap[i] == snap[j]) begin
          dup = 1'b1;
          k   = i;
        end
    t = dup ? k + 1 : 5;
    for (int c = 1; c <= 8; c++) begin
      if (c == t + 1) begin
        if (dup) dup_err_m = 1'b1;
        else begin
          active_m    = snap;
          cfg_valid_m = 1'b1;
        end
      end
      chk("port_addr", port_addr, active_flat());
      chk("cfg_valid", 32'(cfg_valid), 32'(cfg_valid_m));
      if (inject && c == 2)      do_access(1'b1, 3'd2, 8'($urandom), c <= t);
      else if (inject && c == 3) do_access(1'b0, 3'd1, 8'h00, c <= t);
      else                       do_access(1'b0, 3'd4, 8'h00, c <= t);
    end
  endtask

  initial begin
    int         r;
    logic [7:0] w;
    reset     = 1'b1;
    mem_en    = 1'b0;
    mem_rd_wr = 1'b0;
    mem_add   = 3'd0;
    mem_wdata = 8'h00;
    model_reset();
    repeat (3) step();
    reset = 1'b0;

    chk("rst_rdata", 32'(mem_rdata), 32'd0);
    chk("rst_rvalid", 32'(mem_rvalid), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_port_addr", port_addr, 32'd0);
    chk("rst_cfg_valid", 32'(cfg_valid), 32'd0);

    for (int i = 0; i < 4; i++) do_access(1'b1, 3'(i), 8'(17 * (i + 1)), 1'b0);
    for (int i = 0; i < 4; i++) do_access(1'b0, 3'(i), 8'h00, 1'b0);
    chk("pre_commit_port_addr", port_addr, 32'd0);
    chk("pre_commit_cfg_valid", 32'(cfg_valid), 32'd0);

    run_commit(8'h01, 1'b0);
    chk("commit_value", port_addr, 32'h44332211);

    do_access(1'b1, 3'd3, 8'h22, 1'b0);
    run_commit(8'h01, 1'b0);
    do_access(1'b0, 3'd4, 8'h00, 1'b0);
    chk("dup_csr", 32'(mem_rdata), 32'h0C);
    chk("dup_port_addr", port_addr, 32'h44332211);

    do_access(1'b1, 3'd3, 8'h55, 1'b0);
    run_commit(8'h05, 1'b1);

    do_access(1'b0, 3'd5, 8'h00, 1'b0);
    do_access(1'b1, 3'd7, 8'hAA, 1'b0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) do_access(1'b1, 3'($urandom_range(0, 3)), 8'(17 * $urandom_range(1, 6)), 1'b0);
      else if (r <= 5) do_access(1'b0, 3'($urandom_range(0, 3)), 8'h00, 1'b0);
      else if (r == 6) do_access(1'b0, 3'd4, 8'h00, 1'b0);
      else if (r == 7) do_access(1'($urandom_range(0, 1)), 3'($urandom_range(5, 7)), 8'($urandom), 1'b0);
      else if (r == 8) begin
        w = 8'($urandom);
        if (w[0]) run_commit(w, 1'($urandom_range(0, 1)));
        else      do_access(1'b1, 3'd4, w, 1'b0);
      end else begin
        chk("rand_port_addr", port_addr, active_flat());
        chk("rand_cfg_valid", 32'(cfg_valid), 32'(cfg_valid_m));
      end
    end

    for (int i = 0; i < 4; i++) do_access(1'b1, 3'(i), 8'(16 * i + 1), 1'b0);
    do_access(1'b1, 3'd4, 8'h01, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    chk("abort_rdata", 32'(mem_rdata), 32'd0);
    chk("abort_rvalid", 32'(mem_rvalid), 32'd0);
    chk("abort_err", 32'(mem_err), 32'd0);
    chk("abort_port_addr", port_addr, 32'd0);
    chk("abort_cfg_valid", 32'(cfg_valid), 32'd0);
    repeat (7) begin
      step();
      chk("abort_no_commit", port_addr, 32'd0);
      chk("abort_cfg_low", 32'(cfg_valid), 32'd0);
    end
    do_access(1'b0, 3'd4, 8'h00, 1'b0);
    do_access(1'b0, 3'd0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
